// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants, immediate format codes and format classification.
package imm_gen_pipe_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned FMT_W  = 3;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate format codes, shared with the control decoder
  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } imm_fmt_e;

  // Map opcode/funct3 to an immediate format; unknown opcodes are illegal
  function automatic imm_fmt_e classify_fmt(input logic [6:0] opcode, input logic [2:0] funct3);
    imm_fmt_e f;
    f = FMT_ILLEGAL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
        OPC_OP_IMM: f = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? FMT_SHAMT : FMT_I;
        OPC_STORE:  f = FMT_S;
        OPC_BRANCH: f = FMT_B;
        OPC_LUI, OPC_AUIPC: f = FMT_U;
        OPC_JAL:    f = FMT_J;
        OPC_OP:     f = FMT_R;
        default:    f = FMT_ILLEGAL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: raw instruction -> XLEN immediate, format, illegal flag.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] i_inst,
  output logic [XLEN-1:0]   o_imm,
  output logic [FMT_W-1:0]  o_fmt,
  output logic              o_illegal
);

  imm_fmt_e           w_fmt;
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;

  assign w_fmt   = classify_fmt(i_inst[6:0], i_inst[14:12]);
  assign w_imm_i = i_inst[31:20];
  assign w_imm_s = {i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Select and sign-extend the immediate for the decoded format
  always_comb begin
    o_imm     = '0;
    o_fmt     = w_fmt;
    o_illegal = (w_fmt == FMT_ILLEGAL);
    case (w_fmt)
      FMT_I:     o_imm = XLEN'(w_imm_i);
      FMT_S:     o_imm = XLEN'(w_imm_s);
      FMT_B:     o_imm = XLEN'(w_imm_b);
      FMT_U:     o_imm = XLEN'(w_imm_u);
      FMT_J:     o_imm = XLEN'(w_imm_j);
      // shift amounts are unsigned; RV64 uses one extra bit
      FMT_SHAMT: o_imm = (XLEN == 64) ? XLEN'(i_inst[25:20]) : XLEN'(i_inst[24:20]);
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer and illegal-opcode counter.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [FMT_W-1:0]  out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  illegal_cnt
);

  logic [XLEN-1:0]  w_dec_imm;
  logic [FMT_W-1:0] w_dec_fmt;
  logic             w_dec_ill;
  logic             w_accept;
  logic             w_drain;

  logic             r_main_valid;
  logic [XLEN-1:0]  r_main_imm;
  logic [FMT_W-1:0] r_main_fmt;
  logic             r_main_ill;
  logic [TAG_W-1:0] r_main_tag;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [FMT_W-1:0] r_skid_fmt;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;

  logic [CNT_W-1:0] r_cnt;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_inst    (in_inst),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_ill)
  );

  // Accept only while the skid slot is free; flush blocks new entries
  assign in_ready = !r_skid_valid && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_main_valid && out_ready;

  // Main/skid storage, FIFO ordered; flush clears valids but output handshake still counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_fmt   <= '0;
      r_main_ill   <= 1'b0;
      r_main_tag   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= '0;
      r_skid_ill   <= 1'b0;
      r_skid_tag   <= '0;
      r_cnt        <= '0;
    end else begin
      if (w_drain && r_main_ill && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_drain) begin
        if (r_skid_valid) begin
          // skid is older than anything upstream, so it moves up first
          r_main_valid <= 1'b1;
          r_main_imm   <= r_skid_imm;
          r_main_fmt   <= r_skid_fmt;
          r_main_ill   <= r_skid_ill;
          r_main_tag   <= r_skid_tag;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_accept;
          if (w_accept) begin
            r_main_imm <= w_dec_imm;
            r_main_fmt <= w_dec_fmt;
            r_main_ill <= w_dec_ill;
            r_main_tag <= in_tag;
          end
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_imm   <= w_dec_imm;
        r_skid_fmt   <= w_dec_fmt;
        r_skid_ill   <= w_dec_ill;
        r_skid_tag   <= in_tag;
      end
    end
  end

  assign out_valid   = r_main_valid;
  assign out_imm     = r_main_imm;
  assign out_fmt     = r_main_fmt;
  assign out_illegal = r_main_ill;
  assign out_tag     = r_main_tag;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share stimulus and a queue model.
module tb_imm_gen_pipe;

  localparam int unsigned TAG_W   = 32;
  localparam int          NV      = 16;
  localparam int          IDX_ILL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready_a, out_valid_a, out_ill_a;
  logic [31:0]      out_imm_a;
  logic [2:0]       out_fmt_a;
  logic [TAG_W-1:0] out_tag_a;
  logic [7:0]       cnt_a;

  logic             in_ready_b, out_valid_b, out_ill_b;
  logic [63:0]      out_imm_b;
  logic [2:0]       out_fmt_b;
  logic [TAG_W-1:0] out_tag_b;
  logic [1:0]       cnt_b;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
    .out_illegal(out_ill_a), .out_tag(out_tag_a), .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
    .out_illegal(out_ill_b), .out_tag(out_tag_b), .illegal_cnt(cnt_b)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } vec_t;

  typedef struct {
    vec_t             v;
    logic [TAG_W-1:0] tag;
  } ent_t;

  vec_t tbl [NV];
  ent_t q [$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   cur_idx = 0;
  int   tag_seq = 0;
  int   timeout_cnt = 0;
  int   cnt_a_m = 0;
  int   cnt_b_m = 0;
  logic mon_en = 1'b0;
  logic end_check = 1'b0;
  logic prev_reset = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor/scoreboard: compare against queue model, then advance the model
  always @(negedge clk) begin : mon
    ent_t e;
    logic acc, drn;
    if (mon_en) begin
      chk("in_ready_a", 64'(in_ready_a), 64'(!(q.size() >= 2) && !flush));
      chk("in_ready_b", 64'(in_ready_b), 64'(!(q.size() >= 2) && !flush));
      chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
      chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        chk("imm32", 64'(out_imm_a), 64'(e.v.imm32));
        chk("imm64", out_imm_b, e.v.imm64);
        chk("fmt_a", 64'(out_fmt_a), 64'(e.v.fmt));
        chk("fmt_b", 64'(out_fmt_b), 64'(e.v.fmt));
        chk("illegal_a", 64'(out_ill_a), 64'(e.v.fmt == 3'd7));
        chk("illegal_b", 64'(out_ill_b), 64'(e.v.fmt == 3'd7));
        chk("tag_a", 64'(out_tag_a), 64'(e.tag));
        chk("tag_b", 64'(out_tag_b), 64'(e.tag));
      end
      chk("cnt_a", 64'(cnt_a), 64'(cnt_a_m));
      chk("cnt_b", 64'(cnt_b), 64'(cnt_b_m));
      if (prev_reset && !reset) begin
        chk("rst_imm_a", 64'(out_imm_a), 64'h0);
        chk("rst_imm_b", out_imm_b, 64'h0);
        chk("rst_fmt_a", 64'(out_fmt_a), 64'h0);
        chk("rst_ill_b", 64'(out_ill_b), 64'h0);
        chk("rst_tag_a", 64'(out_tag_a), 64'h0);
        chk("rst_tag_b", 64'(out_tag_b), 64'h0);
      end
      if (end_check) begin
        chk("queue_empty_at_end", 64'(q.size()), 64'h0);
        chk("send_timeouts", 64'(timeout_cnt), 64'h0);
      end
      acc = in_valid && in_ready_a;
      drn = out_valid_a && out_ready;
      if (reset) begin
        q.delete();
        cnt_a_m = 0;
        cnt_b_m = 0;
      end else begin
        if (drn && q.size() != 0) begin
          e = q.pop_front();
          if (e.v.fmt == 3'd7) begin
            if (cnt_a_m < 255) cnt_a_m++;
            if (cnt_b_m < 3)   cnt_b_m++;
          end
        end
        if (flush) q.delete();
        else if (acc) begin
          e.v   = tbl[cur_idx];
          e.tag = in_tag;
          q.push_back(e);
        end
      end
      prev_reset = reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int idx, input logic v);
    cur_idx  = idx;
    in_inst  = tbl[idx].inst;
    in_valid = v;
    tag_seq++;
    in_tag   = 32'hC0DE_0000 | TAG_W'(tag_seq);
  endtask

  // Offer one instruction until accepted, bounded
  task automatic send(input int idx);
    logic acc;
    set_in(idx, 1'b1);
    for (int k = 0; k < 20; k++) begin
      #1;
      acc = in_ready_a;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    timeout_cnt++;
    in_valid = 1'b0;
  endtask

  initial begin
    logic pend, acc;
    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1};
    tbl[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2};
    tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd3};
    tbl[3]  = '{32'h123452B7, 32'h12345000, 64'h00000000_12345000, 3'd4};
    tbl[4]  = '{32'h01F09093, 32'h0000001F, 64'h00000000_0000001F, 3'd6};
    tbl[5]  = '{32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 3'd6};
    tbl[6]  = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd7};
    tbl[7]  = '{32'h003100B3, 32'h00000000, 64'h00000000_00000000, 3'd0};
    tbl[8]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd5};
    tbl[9]  = '{32'h80000017, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4};
    tbl[10] = '{32'h7FF08067, 32'h000007FF, 64'h00000000_000007FF, 3'd1};
    tbl[11] = '{32'h80012083, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 3'd1};
    tbl[12] = '{32'h00000073, 32'h00000000, 64'h00000000_00000000, 3'd1};
    tbl[13] = '{32'hFFF00090, 32'h00000000, 64'h00000000_00000000, 3'd7};
    tbl[14] = '{32'h4030D093, 32'h00000003, 64'h00000000_00000003, 3'd6};
    tbl[15] = '{32'h00208463, 32'h00000008, 64'h00000000_00000008, 3'd3};

    tick();
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Table stream with no backpressure
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    repeat (3) tick();

    // Illegal consumes: 8-bit counter keeps counting, 2-bit counter saturates
    repeat (5) send(IDX_ILL);
    repeat (3) tick();

    // Backpressure: A to main, B to skid, C held, then drain in order
    out_ready = 1'b0;
    set_in(0, 1'b1); tick();
    set_in(1, 1'b1); tick();
    set_in(2, 1'b1); tick();
    out_ready = 1'b1;
    send(2);
    repeat (3) tick();

    // Flush with both entries full and an offered instruction
    out_ready = 1'b0;
    set_in(3, 1'b1); tick();
    set_in(8, 1'b1); tick();
    set_in(9, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush while an illegal entry drains: the drain still counts
    set_in(IDX_ILL, 1'b1); tick();
    set_in(10, 1'b1); tick();
    out_ready = 1'b1;
    set_in(11, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // Random traffic with occasional flush; offers held until accepted
    pend = 1'b0;
    repeat (120) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0) begin
          set_in(int'($urandom_range(0, NV - 1)), 1'b1);
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      acc = in_valid && in_ready_a;
      tick();
      if (acc) pend = 1'b0;
    end
    flush = 1'b0;
    in_valid = 1'b0;

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    set_in(IDX_ILL, 1'b1); tick();
    set_in(4, 1'b1); tick();
    in_valid = 1'b0;
    set_in(5, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    send(5);
    send(14);
    send(IDX_ILL);

    repeat (3) tick();
    end_check = 1'b1;
    tick();
    end_check = 1'b0;
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
